// File: rtl/mod_msg_sched.sv
// SHA-256 message-schedule sequencer: loads 16 words, emits W0..W(OUT_WORDS-1) from a 16-word window.
// Optional OUT_IDX port enabled by defining MSG_SCHED_IDX_EN.
module mod_msg_sched #(
    parameter int unsigned OUT_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ABORT,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [0:31] IN_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [0:31] OUT_DATA,
`ifdef MSG_SCHED_IDX_EN
    output logic [0:5]  OUT_IDX,
`endif
    output logic        DONE
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned WIN_DEPTH = 16;
    localparam int unsigned CNT_W     = 6;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(WIN_DEPTH - 1);
    localparam logic [CNT_W-1:0] EMIT_LAST = CNT_W'(OUT_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_shift;
    logic [WORD_W-1:0]   w_shift_data;
    logic [WORD_W-1:0]   w_next;
    logic [WORD_W-1:0]   r_win [WIN_DEPTH];

    // Small sigma functions of the SHA-256 schedule (MOD_SIGMA0 / MOD_SIGMA1).
    function automatic logic [WORD_W-1:0] f_sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] f_sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // With r_win[0] = W(t), this is W(t+16).
    assign w_next = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;
        w_shift      = 1'b0;
        w_shift_data = w_next;
        if (ABORT) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                end
                ST_LOAD: begin
                    if (IN_VALID) begin
                        w_shift      = 1'b1;
                        w_shift_data = IN_DATA;
                        if (r_cnt == LOAD_LAST) begin
                            w_state_nxt = ST_EMIT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (OUT_READY) begin
                        w_shift = 1'b1;
                        if (r_cnt == EMIT_LAST) begin
                            w_state_nxt = ST_LOAD;
                            w_cnt_nxt   = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Sliding window: oldest word at index 0, new word enters at the top.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_shift) begin
            for (int i = 0; i < WIN_DEPTH - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[WIN_DEPTH-1] <= w_shift_data;
        end
    end

    assign IN_READY  = (r_state == ST_LOAD);
    assign OUT_VALID = (r_state == ST_EMIT);
    assign OUT_DATA  = (r_state == ST_EMIT) ? r_win[0] : '0;
    assign DONE      = r_done;
`ifdef MSG_SCHED_IDX_EN
    assign OUT_IDX   = (r_state == ST_EMIT) ? r_cnt : '0;
`endif

endmodule

// File: tb/tb_mod_msg_sched.sv
// Randomized bench for mod_msg_sched against a schedule-level reference model.
// A second instance built with OUT_WORDS=16 shadows the main one on the same input stream.
module tb_mod_msg_sched;

    localparam int OW = 64;

    logic        CLK       = 1'b0;
    logic        RST_N     = 1'b0;
    logic        ABORT     = 1'b0;
    logic        IN_VALID  = 1'b0;
    logic        OUT_READY = 1'b0;
    logic        READY16   = 1'b1;
    logic [0:31] IN_DATA   = '0;
    logic        IN_READY, OUT_VALID, DONE;
    logic        IN_READY16, OUT_VALID16, DONE16;
    logic [0:31] OUT_DATA, OUT_DATA16;
`ifdef MSG_SCHED_IDX_EN
    logic [0:5]  OUT_IDX, OUT_IDX16;
`endif

    mod_msg_sched #(.OUT_WORDS(OW)) dut (
        .CLK(CLK), .RST_N(RST_N), .ABORT(ABORT),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
`ifdef MSG_SCHED_IDX_EN
        .OUT_IDX(OUT_IDX),
`endif
        .DONE(DONE)
    );

    mod_msg_sched #(.OUT_WORDS(16)) dut16 (
        .CLK(CLK), .RST_N(RST_N), .ABORT(ABORT),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY16), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID16), .OUT_READY(READY16), .OUT_DATA(OUT_DATA16),
`ifdef MSG_SCHED_IDX_EN
        .OUT_IDX(OUT_IDX16),
`endif
        .DONE(DONE16)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference schedule: W(t) = s1(W(t-2)) + W(t-7) + s0(W(t-15)) + W(t-16).
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [31:0] m_blk [16];
    logic [31:0] m_w   [64];
    logic [31:0] b16   [16];
    logic [31:0] cur   [16];
    logic [31:0] got   [$];

    function automatic void build_sched();
        for (int t = 0; t < 16; t++) m_w[t] = m_blk[t];
        for (int t = 16; t < 64; t++)
            m_w[t] = ss1(m_w[t-2]) + m_w[t-7] + ss0(m_w[t-15]) + m_w[t-16];
    endfunction

    // Model: 0 idle, 1 loading, 2 emitting; m_nin/m_nout count transferred words.
    int m_mode = 0, m_nin = 0, m_nout = 0, m_loads = 0, n16 = 16, dones16 = 0;
    bit m_done = 1'b0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            chk("rst_in_ready", 32'(IN_READY), 0);
            chk("rst_out_valid", 32'(OUT_VALID), 0);
            chk("rst_out_data", OUT_DATA, 0);
            chk("rst_done", 32'(DONE), 0);
            chk("rst16_valid", 32'(OUT_VALID16), 0);
`ifdef MSG_SCHED_IDX_EN
            chk("rst_out_idx", 32'(OUT_IDX), 0);
`endif
            m_mode = 0;
            m_done = 1'b0;
            n16    = 16;
        end else begin
            chk("in_ready", 32'(IN_READY), 32'(m_mode == 1));
            chk("out_valid", 32'(OUT_VALID), 32'(m_mode == 2));
            chk("done", 32'(DONE), 32'(m_done));
            if (m_mode == 2) begin
                chk("out_data", OUT_DATA, m_w[m_nout]);
`ifdef MSG_SCHED_IDX_EN
                chk("out_idx", 32'(OUT_IDX), 32'(m_nout));
`endif
            end
            if (DONE16) begin
                chk("d16_done_after_16", 32'(n16), 16);
                dones16++;
            end
            if (OUT_VALID16) begin
                chk("d16_in_range", 32'(n16 < 16), 1);
                if (n16 < 16) begin
                    chk("d16_data", OUT_DATA16, b16[n16]);
`ifdef MSG_SCHED_IDX_EN
                    chk("d16_idx", 32'(OUT_IDX16), 32'(n16));
`endif
                end
                n16++;
            end
            if (OUT_VALID && OUT_READY && !ABORT) got.push_back(OUT_DATA);
            m_done = 1'b0;
            if (ABORT) begin
                m_mode = 0;
            end else begin
                case (m_mode)
                    0: begin m_mode = 1; m_nin = 0; end
                    1: if (IN_VALID) begin
                        m_blk[m_nin] = IN_DATA;
                        m_nin++;
                        if (m_nin == 16) begin
                            build_sched();
                            m_mode = 2; m_nout = 0; m_loads++;
                            b16 = m_blk; n16 = 0;
                        end
                    end
                    default: if (OUT_READY) begin
                        m_nout++;
                        if (m_nout == OW) begin m_mode = 1; m_nin = 0; m_done = 1'b1; end
                    end
                endcase
            end
        end
    end

    task automatic set_abc();
        for (int i = 0; i < 16; i++) cur[i] = 32'h0;
        cur[0]  = 32'h61626380;
        cur[15] = 32'h00000018;
    endtask

    // Offer the 16 words of cur with random bubbles; stops once all are accepted.
    task automatic feed(input int gap_pct);
        int i = 0, guard = 0;
        bit fire;
        while (i < 16 && guard < 1000) begin
            IN_VALID = ($urandom_range(0, 99) >= 32'(gap_pct));
            IN_DATA  = IN_VALID ? cur[i] : $urandom();
            @(negedge CLK);
            fire = IN_VALID && IN_READY;
            @(posedge CLK); #1;
            if (fire) i++;
            guard++;
        end
        IN_VALID = 1'b0;
        if (i < 16) begin
            checks++; errors++;
            $display("FAIL feed_timeout accepted=%0d required=16", i);
        end
    endtask

    // Consume outputs with random backpressure; abort_at >= 0 aborts at that index.
    task automatic drain(input int bp_pct, input int abort_at);
        int n = 0, guard = 0;
        bit fin = 1'b0, fire;
        while (!fin && guard < 3000) begin
            ABORT     = (abort_at == n) && OUT_VALID;
            OUT_READY = ABORT || ($urandom_range(0, 99) >= 32'(bp_pct));
            @(negedge CLK);
            fire = OUT_VALID && OUT_READY && !ABORT;
            if (ABORT) fin = 1'b1;
            @(posedge CLK); #1;
            ABORT = 1'b0;
            if (fire) n++;
            if (DONE) fin = 1'b1;
            guard++;
        end
        OUT_READY = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL drain_timeout words=%0d required_end=1", n);
        end
    endtask

    initial begin
        // Pin the model on the "abc" block.
        set_abc();
        m_blk = cur;
        build_sched();
        chk("model_w16", m_w[16], 32'h61626380);
        chk("model_w17", m_w[17], 32'h000F0000);
        chk("model_w63", m_w[63], 32'h12B1EDEB);

        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        chk("ready_at_release", 32'(IN_READY), 0);
        @(posedge CLK); #1;
        chk("ready_one_edge_later", 32'(IN_READY), 1);

        // Gap-free abc, no backpressure.
        got.delete();
        feed(0);
        drain(0, -1);
        chk("abc_count", 32'(got.size()), 64);
        chk("abc_w0", got[0], 32'h61626380);
        chk("abc_w16", got[16], 32'h61626380);
        chk("abc_w17", got[17], 32'h000F0000);
        chk("abc_w63", got[63], 32'h12B1EDEB);
        chk("ready_with_done", 32'(IN_READY), 1);

        // Backpressure, then input bubbles.
        got.delete();
        feed(0);
        drain(50, -1);
        chk("bp_count", 32'(got.size()), 64);
        chk("bp_w63", got[63], 32'h12B1EDEB);
        got.delete();
        feed(40);
        drain(0, -1);
        chk("gap_w17", got[17], 32'h000F0000);

        // Abort at index 20, then a clean block.
        got.delete();
        feed(0);
        drain(0, 20);
        chk("abort_count", 32'(got.size()), 20);
        got.delete();
        feed(0);
        drain(0, -1);
        chk("post_abort_w63", got[63], 32'h12B1EDEB);

        // Random blocks with random bubbles and backpressure.
        repeat (4) begin
            for (int i = 0; i < 16; i++) cur[i] = $urandom();
            feed(30);
            drain(30, -1);
        end

        // Reset mid-emit, then abc again.
        set_abc();
        feed(0);
        OUT_READY = 1'b1;
        repeat (25) @(posedge CLK);
        #1 RST_N = 1'b0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        got.delete();
        feed(20);
        drain(20, -1);
        chk("post_reset_w63", got[63], 32'h12B1EDEB);

        @(posedge CLK); #1;
        chk("d16_done_count", 32'(dones16), 32'(m_loads));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
